vga_sync_tracker: RTL and testbench
===================================

VGA_SYNC_TRACKER -- requirements
Module: vga_sync_tracker

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 11, setting the width of the horizontal and vertical counters and measurements.
REQ-002 SHALL have parameter SYNC_ACTIVE_LOW, default 1; when 1, sync is asserted when the pin is 0, and when 0, it is asserted when the pin is 1.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, setting the number of consecutive matching frames required for lock.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port hsync, input, 1 bit: horizontal sync from the VGA timing generator, synchronous to clk.
REQ-007 SHALL have port vsync, input, 1 bit: vertical sync, synchronous to clk.
REQ-008 SHALL have port x, output, CNT_WIDTH bits: clocks since the last hsync leading edge.
REQ-009 SHALL have port y, output, CNT_WIDTH bits: hsync leading edges since the last vsync leading edge.
REQ-010 SHALL have port h_period, output, CNT_WIDTH bits: the last measured line length in clocks.
REQ-011 SHALL have port v_lines, output, CNT_WIDTH bits: the last measured frame length in lines.
REQ-012 SHALL have port line_pulse, output, 1 bit: a one-cycle strobe per hsync leading edge.
REQ-013 SHALL have port frame_pulse, output, 1 bit: a one-cycle strobe per vsync leading edge.
REQ-014 SHALL have port locked, output, 1 bit: high while the timing is stable.
REQ-015 SHALL have port lock_err, output, 1 bit: a one-cycle strobe when lock is lost.

Function
REQ-016 SHALL register hsync and vsync once (stage s) and again (stage d); a leading edge is stage s asserted while stage d is deasserted.
REQ-017 SHALL produce registered outputs, so each output reflects an input leading edge exactly 2 clk edges after the pin first asserts.
REQ-018 On an h leading edge, SHALL set x to 0 and h_period to (x+1), and pulse line_pulse; otherwise x SHALL increment by 1 and saturate at 2^CNT_WIDTH-1 with no wrap.
REQ-019 On an h leading edge, SHALL increment y, saturating at all-ones.
REQ-020 On a v leading edge, SHALL set v_lines to (y+1), set y to 0, and pulse frame_pulse.
REQ-021 When h and v leading edges coincide, SHALL apply the v update to y (y becomes 0) and still apply the h update to x and h_period.
REQ-022 SHALL implement the state machine SEARCH, MEASURE, LOCKED; match_cnt counts up to LOCK_FRAMES.
REQ-023 In SEARCH, on the first v leading edge, SHALL capture ref_h (the current h_period) and go to MEASURE with match_cnt=0.
REQ-024 SHALL set line_bad if any h leading edge within the frame produces an h_period different from ref_h.
REQ-025 In MEASURE, at each v leading edge, the frame SHALL match if line_bad is clear and (y+1) equals the previous v_lines; a match increments match_cnt.
REQ-026 In MEASURE, at match_cnt reaching LOCK_FRAMES, SHALL go to LOCKED; a mismatch SHALL reset match_cnt to 0 and reload ref_h.
REQ-027 In LOCKED, any line-period mismatch or frame-length mismatch SHALL go to SEARCH and pulse lock_err once.
REQ-028 SHALL register locked high only in LOCKED; it falls on the same edge that leaves LOCKED.
REQ-029 Saturation of x (no hsync) while in MEASURE or LOCKED SHALL be treated as a mismatch.
REQ-030 SHALL clear line_bad at every v leading edge.

Reset
REQ-031 While rst is high at a clk edge, SHALL clear x, y, h_period, v_lines, ref_h, match_cnt and line_bad to 0, and hold line_pulse, frame_pulse, locked and lock_err at 0.
REQ-032 During reset, SHALL load the sync stages with the deasserted level and set the state to SEARCH.
REQ-033 A reset asserted mid-frame or while locked SHALL take effect on the next edge; no strobe is emitted during or on the cycle after reset.

Verification
REQ-034 Reset: rst high for 3 cycles with hsync toggling -> all outputs 0, state SEARCH, no pulses.
REQ-035 Stable timing (line 20 clk, hsync low 4 clk; frame 10 lines, vsync low 2 lines) -> h_period=20, v_lines=10; locked rises at the 3rd v leading edge after the first (LOCK_FRAMES=2); x counts 0..19; y counts 0..9.
REQ-036 While locked, one line stretched to 21 clk -> lock_err pulses once at that line's edge+2, locked drops the same cycle, state SEARCH; relock takes 3 further frames.
REQ-037 Coincident edges: hsync and vsync asserting on the same clk -> y=0, x=0, line_pulse=1, frame_pulse=1 on the same cycle.
REQ-038 Stalled hsync for 2^11 clk while locked -> x holds at 2047, lock_err pulses, locked=0.
REQ-039 Reset asserted mid-line while locked -> next cycle locked=0 and lock_err=0; after rst drops, lock sequence restarts from SEARCH.

Source files
------------

// File: rtl/vga_sync_tracker.sv
// Recovers raster position from VGA hsync/vsync, measures line and frame length,
// and declares lock once the timing has repeated for LOCK_FRAMES frames.
module vga_sync_tracker #(
    parameter int CNT_WIDTH       = 11,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hsync,
    input  logic                 vsync,
    output logic [CNT_WIDTH-1:0] x,
    output logic [CNT_WIDTH-1:0] y,
    output logic [CNT_WIDTH-1:0] h_period,
    output logic [CNT_WIDTH-1:0] v_lines,
    output logic                 line_pulse,
    output logic                 frame_pulse,
    output logic                 locked,
    output logic                 lock_err
);

    localparam logic                 IDLE_LVL    = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam int                   MW          = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0]        LOCK_TARGET = MW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_MEASURE,
        ST_LOCKED
    } state_e;

    // Sync pipeline holds raw pin levels; polarity is applied when decoding.
    logic hs_s_q, hs_d_q, vs_s_q, vs_d_q;

    logic [CNT_WIDTH-1:0] x_q, x_d;
    logic [CNT_WIDTH-1:0] y_q, y_d;
    logic [CNT_WIDTH-1:0] h_period_q, h_period_d;
    logic [CNT_WIDTH-1:0] v_lines_q, v_lines_d;
    logic [CNT_WIDTH-1:0] ref_h_q, ref_h_d;
    logic [MW-1:0]        match_cnt_q, match_cnt_d;
    logic                 line_bad_q, line_bad_d;
    logic                 line_pulse_q, frame_pulse_q, locked_q, lock_err_q;
    logic                 lock_err_d;
    state_e               state_q, state_d;

    logic                 h_edge, v_edge;
    logic [CNT_WIDTH-1:0] line_len, frame_len;
    logic                 h_mis, x_sat, len_mis, line_bad_now;

    function automatic logic is_asserted(input logic lvl);
        return (SYNC_ACTIVE_LOW != 0) ? ~lvl : lvl;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign h_edge = is_asserted(hs_s_q) & ~is_asserted(hs_d_q);
    assign v_edge = is_asserted(vs_s_q) & ~is_asserted(vs_d_q);

    assign line_len  = sat_inc(x_q);
    assign frame_len = sat_inc(y_q);

    // A saturated x means hsync has vanished; that counts as a bad line.
    assign h_mis        = h_edge && (line_len != ref_h_q);
    assign x_sat        = (x_q == CNT_MAX);
    assign len_mis      = (frame_len != v_lines_q);
    assign line_bad_now = line_bad_q | h_mis | x_sat;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        x_d        = sat_inc(x_q);
        y_d        = y_q;
        h_period_d = h_period_q;
        v_lines_d  = v_lines_q;
        line_bad_d = v_edge ? 1'b0 : line_bad_now;

        if (h_edge) begin
            x_d        = '0;
            h_period_d = line_len;
            y_d        = sat_inc(y_q);
        end
        // Vertical update wins on y when both edges land on the same cycle.
        if (v_edge) begin
            v_lines_d = frame_len;
            y_d       = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        ref_h_d     = ref_h_q;
        lock_err_d  = 1'b0;

        unique case (state_q)
            ST_SEARCH: begin
                if (v_edge) begin
                    ref_h_d     = h_period_d;
                    match_cnt_d = '0;
                    state_d     = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                if (v_edge) begin
                    if (!line_bad_now && !len_mis) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_d >= LOCK_TARGET) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_cnt_d = '0;
                        ref_h_d     = h_period_d;
                    end
                end
            end

            ST_LOCKED: begin
                // Line faults drop lock immediately rather than at frame end.
                if (h_mis || x_sat || (v_edge && len_mis)) begin
                    state_d     = ST_SEARCH;
                    match_cnt_d = '0;
                    lock_err_d  = 1'b1;
                end
            end

            default: begin
                state_d     = ST_SEARCH;
                match_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s_q        <= IDLE_LVL;
            hs_d_q        <= IDLE_LVL;
            vs_s_q        <= IDLE_LVL;
            vs_d_q        <= IDLE_LVL;
            x_q           <= '0;
            y_q           <= '0;
            h_period_q    <= '0;
            v_lines_q     <= '0;
            ref_h_q       <= '0;
            match_cnt_q   <= '0;
            line_bad_q    <= 1'b0;
            line_pulse_q  <= 1'b0;
            frame_pulse_q <= 1'b0;
            locked_q      <= 1'b0;
            lock_err_q    <= 1'b0;
            state_q       <= ST_SEARCH;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            hs_s_q        <= hsync;
            hs_d_q        <= hs_s_q;
            vs_s_q        <= vsync;
            vs_d_q        <= vs_s_q;
            x_q           <= x_d;
            y_q           <= y_d;
            h_period_q    <= h_period_d;
            v_lines_q     <= v_lines_d;
            ref_h_q       <= ref_h_d;
            match_cnt_q   <= match_cnt_d;
            line_bad_q    <= line_bad_d;
            line_pulse_q  <= h_edge;
            frame_pulse_q <= v_edge;
            locked_q      <= (state_d == ST_LOCKED);
            lock_err_q    <= lock_err_d;
            state_q       <= state_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign h_period    = h_period_q;
    assign v_lines     = v_lines_q;
    assign line_pulse  = line_pulse_q;
    assign frame_pulse = frame_pulse_q;
    assign locked      = locked_q;
    assign lock_err    = lock_err_q;

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Directed bench for vga_sync_tracker: 20-clk lines, 10-line frames, active-low
// syncs; outputs are sampled 1 time unit after each rising edge.
module tb_vga_sync_tracker;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic         hsync;
    logic         vsync;
    logic [W-1:0] x, y, h_period, v_lines;
    logic         line_pulse, frame_pulse, locked, lock_err;

    int n_checks = 0;
    int n_errors = 0;

    // Raster generator position; last_* is the position driven on the latest edge.
    int hpos = 0, vline = 0, frame_no = 0;
    int last_h = -1, last_v = -1, last_f = -1;
    int stretch_f = -1, stretch_l = -1;

    vga_sync_tracker #(
        .CNT_WIDTH      (W),
        .SYNC_ACTIVE_LOW(1),
        .LOCK_FRAMES    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hsync      (hsync),
        .vsync      (vsync),
        .x          (x),
        .y          (y),
        .h_period   (h_period),
        .v_lines    (v_lines),
        .line_pulse (line_pulse),
        .frame_pulse(frame_pulse),
        .locked     (locked),
        .lock_err   (lock_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one clock of the raster at the current position, then advance it.
    task automatic cyc();
        int len;
        hsync = (hpos < 4) ? 1'b0 : 1'b1;
        vsync = (vline < 2) ? 1'b0 : 1'b1;
        @(posedge clk);
        #1;
        last_h = hpos;
        last_v = vline;
        last_f = frame_no;
        len = (frame_no == stretch_f && vline == stretch_l) ? 21 : 20;
        hpos++;
        if (hpos >= len) begin
            hpos = 0;
            if (vline == 9) begin
                vline = 0;
                frame_no++;
            end else begin
                vline++;
            end
        end
    endtask

    // Run until the edge that sampled position (f, l, c); outputs then reflect (f, l, c-1).
    task automatic run_to(input int f, input int l, input int c);
        bit hit = 1'b0;
        for (int n = 0; n < 5000 && !hit; n++) begin
            cyc();
            hit = (last_f == f && last_v == l && last_h == c);
        end
        check("run_to_reached", 64'(hit), 64'd1);
    endtask

    initial begin
        bit hit;
        int n;

        // Reset held 3 cycles with hsync toggling.
        rst   = 1'b1;
        vsync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hsync = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            check("rst_counters", {x, y, h_period, v_lines}, 64'd0);
            check("rst_flags", {line_pulse, frame_pulse, locked, lock_err}, 64'd0);
        end

        // Start the raster at a frame start, both syncs asserting together.
        rst = 1'b0;
        run_to(0, 0, 0);
        check("post_rst_line_pulse", line_pulse, 1'b0);
        check("post_rst_frame_pulse", frame_pulse, 1'b0);
        run_to(0, 0, 1);
        check("coinc_line_pulse", line_pulse, 1'b1);
        check("coinc_frame_pulse", frame_pulse, 1'b1);
        check("coinc_x", x, 64'd0);
        check("coinc_y", y, 64'd0);
        check("first_v_lines", v_lines, 64'd1);
        run_to(0, 1, 1);
        check("first_h_period", h_period, 64'd20);

        // Frame 1: measurement values and counters.
        run_to(1, 0, 1);
        check("f1_v_lines", v_lines, 64'd10);
        check("f1_h_period", h_period, 64'd20);
        check("f1_locked", locked, 1'b0);
        run_to(1, 3, 1);
        check("f1_l3_y", y, 64'd3);
        check("f1_l3_x", x, 64'd0);
        check("f1_l3_line_pulse", line_pulse, 1'b1);
        run_to(1, 3, 11);
        check("f1_l3_x_mid", x, 64'd10);
        run_to(1, 4, 0);
        check("f1_l3_x_end", x, 64'd19);
        check("f1_l3_no_pulse", line_pulse, 1'b0);
        run_to(1, 9, 1);
        check("f1_l9_y", y, 64'd9);

        // Lock at the third v edge after the first.
        run_to(2, 0, 1);
        check("f2_locked", locked, 1'b0);
        run_to(3, 0, 0);
        check("f3_pre_locked", locked, 1'b0);
        run_to(3, 0, 1);
        check("f3_locked", locked, 1'b1);
        check("f3_frame_pulse", frame_pulse, 1'b1);
        check("f3_x", x, 64'd0);
        check("f3_y", y, 64'd0);

        // Frame 4 line 5 stretched to 21 clocks.
        stretch_f = 4;
        stretch_l = 5;
        run_to(4, 6, 0);
        check("stretch_x", x, 64'd20);
        check("stretch_pre_locked", locked, 1'b1);
        check("stretch_pre_err", lock_err, 1'b0);
        run_to(4, 6, 1);
        check("stretch_lock_err", lock_err, 1'b1);
        check("stretch_locked", locked, 1'b0);
        check("stretch_h_period", h_period, 64'd21);
        run_to(4, 6, 2);
        check("stretch_err_once", lock_err, 1'b0);
        check("stretch_unlocked", locked, 1'b0);
        run_to(5, 0, 1);
        check("relock_f5_v_lines", v_lines, 64'd10);
        check("relock_f5_locked", locked, 1'b0);
        run_to(6, 0, 1);
        check("relock_f6_locked", locked, 1'b0);
        run_to(7, 0, 1);
        check("relock_f7_locked", locked, 1'b1);

        // Stall both syncs while locked until x saturates.
        run_to(7, 1, 1);
        check("stall_start_x", x, 64'd0);
        hsync = 1'b1;
        vsync = 1'b1;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            hit = (x == 11'd2047);
        end
        check("stall_reached", 64'(hit), 64'd1);
        check("stall_cycles", 64'(n), 64'd2047);
        check("stall_sat_locked", locked, 1'b1);
        @(posedge clk);
        #1;
        check("stall_lock_err", lock_err, 1'b1);
        check("stall_locked", locked, 1'b0);
        check("stall_x_hold", x, 64'd2047);
        @(posedge clk);
        #1;
        check("stall_err_once", lock_err, 1'b0);
        check("stall_x_hold2", x, 64'd2047);

        // Resume the raster and relock.
        stretch_f = -1;
        hpos = 0;
        vline = 0;
        frame_no = 0;
        run_to(0, 0, 1);
        check("resume_frame_pulse", frame_pulse, 1'b1);
        check("resume_x", x, 64'd0);
        run_to(2, 0, 1);
        check("resume_f2_locked", locked, 1'b0);
        run_to(3, 0, 1);
        check("resume_f3_locked", locked, 1'b1);

        // Reset mid-line while locked.
        run_to(3, 4, 7);
        check("pre_rst_locked", locked, 1'b1);
        rst = 1'b1;
        cyc();
        check("midrst_locked", locked, 1'b0);
        check("midrst_lock_err", lock_err, 1'b0);
        check("midrst_counters", {x, y, h_period, v_lines}, 64'd0);
        check("midrst_line_pulse", line_pulse, 1'b0);
        rst = 1'b0;
        cyc();
        check("after_rst_pulses", {line_pulse, frame_pulse, lock_err}, 64'd0);
        check("after_rst_locked", locked, 1'b0);
        run_to(4, 0, 1);
        check("rst_seq_v_lines", v_lines, 64'd6);
        check("rst_seq_f4_locked", locked, 1'b0);
        run_to(6, 0, 1);
        check("rst_seq_f6_locked", locked, 1'b0);
        run_to(7, 0, 1);
        check("rst_seq_f7_locked", locked, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
